// File: rtl/mult_div_pkg.sv
// Shared state encoding and sizing helpers for mult_div_unit.
package mult_div_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        MULT = ST_MULT,
        DIV  = ST_DIV,
        DONE = ST_DONE
    } state_t;

    // The counter must hold WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_div_step.sv
// One combinational iteration: a Booth radix-2 multiply step and a restoring divide step.
module mult_div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] mq,
    input  logic             mq_m1,
    input  logic [WIDTH:0]   mcand,
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] mq_next,
    output logic             mq_m1_next,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;

    // NOTE: combinational logic uses blocking '=' and gives every output a default first, so no latch is inferred.
    always_comb begin
        unique case ({mq[0], mq_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        // Accumulator is one bit wider than the operands so that -2^(W-1) multiplicands cannot overflow.
        {acc_next, mq_next, mq_m1_next} = {sum[WIDTH], sum, mq};

        shifted  = {rem, quo[WIDTH-1]};
        rem_next = shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, divisor}) begin
            rem_next    = shifted[WIDTH-1:0] - divisor;
            quo_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit, one iteration per clock, registered hi/lo/busy/done.
// Build option DIV_ZERO_TRAP_EN: divide by zero finishes early with div_by_zero and leaves hi/lo alone.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    localparam int CW = cnt_width(WIDTH);
`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH:0]   acc, mcand, acc_next;
    logic [WIDTH-1:0] mq, mq_next, rem, rem_next, quo, quo_next, divisor;
    logic             mq_m1, mq_m1_next;
    logic             a_neg, q_neg, div_zero;
    logic             last_step;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign last_step = (counter == CW'(1));

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc),
        .mq         (mq),
        .mq_m1      (mq_m1),
        .mcand      (mcand),
        .rem        (rem),
        .quo        (quo),
        .divisor    (divisor),
        .acc_next   (acc_next),
        .mq_next    (mq_next),
        .mq_m1_next (mq_m1_next),
        .rem_next   (rem_next),
        .quo_next   (quo_next)
    );

    // NOTE: the datapath registers are reset along with the FSM so nothing downstream ever sees X.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            acc         <= '0;
            mcand       <= '0;
            mq          <= '0;
            mq_m1       <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            a_neg       <= 1'b0;
            q_neg       <= 1'b0;
            div_zero    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done        <= 1'b0;
                    div_by_zero <= 1'b0;
                    if (start_mult) begin
                        acc      <= '0;
                        mcand    <= {op_a[WIDTH-1], op_a};
                        mq       <= op_b;
                        mq_m1    <= 1'b0;
                        div_zero <= 1'b0;
                        counter  <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= MULT;
                    end else if (start_div) begin
                        rem      <= '0;
                        quo      <= magnitude(op_a);
                        divisor  <= magnitude(op_b);
                        a_neg    <= op_a[WIDTH-1];
                        q_neg    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        div_zero <= (op_b == '0);
                        counter  <= CW'(WIDTH);
                        busy     <= 1'b1;
                        state    <= DIV;
                    end
                end
                MULT: begin
                    acc     <= acc_next;
                    mq      <= mq_next;
                    mq_m1   <= mq_m1_next;
                    counter <= counter - 1'b1;
                    if (last_step) begin
                        hi    <= acc_next[WIDTH-1:0];
                        lo    <= mq_next;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DIV: begin
                    if (TRAP_EN && div_zero) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        rem     <= rem_next;
                        quo     <= quo_next;
                        counter <= counter - 1'b1;
                        if (last_step) begin
                            // Divide by zero yields all-ones quotient; remainder sign fixup restores op_a.
                            lo    <= div_zero ? '1 : (q_neg ? -quo_next : quo_next);
                            hi    <= a_neg ? -rem_next : rem_next;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done        <= 1'b1;
                    div_by_zero <= TRAP_EN && div_zero;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level arithmetic model plus directed literal checks.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start_mult = 1'b0;
    logic         start_div = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done, div_by_zero;

    int n_vec = 0;
    int n_fail = 0;
    int n_checks = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_mult  (start_mult),
        .start_div   (start_div),
        .op_a        (op_a),
        .op_b        (op_b),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Architectural result of one operation and how many edges the unit stays busy.
    function automatic void ref_op(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] h, output logic [W-1:0] l,
                                   output bit dbz, output int len, output bit upd);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dbz = 1'b0; len = W; upd = 1'b1; h = '0; l = '0;
        if (is_mult) begin
            p = sa * sb;
            h = p[63:32];
            l = p[31:0];
        end else if (b == '0) begin
`ifdef DIV_ZERO_TRAP_EN
            dbz = 1'b1; len = 1; upd = 1'b0;
`else
            h = a; l = '1;
`endif
        end else begin
            q = sa / sb;
            r = sa % sb;
            h = r[31:0];
            l = q[31:0];
        end
    endfunction

    // Model state: time since the last accepted operation and the visible hi/lo.
    bit           m_active = 1'b0, m_upd = 1'b0, m_dbz = 1'b0;
    int           m_age = 0, m_len = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active = 1'b0; m_age = 0; m_len = 0; m_upd = 1'b0; m_dbz = 1'b0;
            m_hi = '0; m_lo = '0;
        end else begin
            if (m_active) begin
                m_age++;
                if (m_age == m_len && m_upd) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end
            if ((!m_active || m_age >= m_len + 2) && (start_mult || start_div)) begin
                ref_op(start_mult, op_a, op_b, p_hi, p_lo, m_dbz, m_len, m_upd);
                m_active = 1'b1;
                m_age = 0;
            end
        end
    end

    logic [66:0] cmp_exp;
    always @(negedge clock) begin
        cmp_exp = {m_active && (m_age < m_len),
                   m_active && (m_age == m_len + 1),
                   m_active && (m_age == m_len + 1) && m_dbz,
                   m_hi, m_lo};
        check("cycle {busy,done,dbz,hi,lo}", {busy, done, div_by_zero, hi, lo}, cmp_exp);
    end

    // Issue one op at the next edge, then wait (bounded) for done.
    task automatic run_op(input bit sm, input bit sd, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mid, output int lat, output int bcnt,
                          output logic [W-1:0] h, output logic [W-1:0] l, output logic dz);
        @(negedge clock);
        start_mult = sm; start_div = sd; op_a = a; op_b = b;
        n_vec++;
        lat = -1; bcnt = 0; h = 'x; l = 'x; dz = 1'bx;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (k == 0) begin
                start_mult = 1'b0;
                op_a = $urandom;
                op_b = $urandom;
            end
            start_div = (k == mid);
            bcnt += int'(busy);
            if (done) begin
                lat = k; h = hi; l = lo; dz = div_by_zero;
                break;
            end
        end
        start_div = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return '1;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    int           lat, bcnt, exp_lat;
    logic [W-1:0] rh, rl;
    logic         rdz;
    bit           sm, sd;
    logic [W-1:0] ra, rb;

    initial begin
        repeat (3) @(negedge clock);
        check("reset state", {busy, done, div_by_zero, hi, lo}, 67'd0);
        reset = 1'b0;

        run_op(1, 0, 32'd3, 32'd5, -1, lat, bcnt, rh, rl, rdz);
        check("3x5 result", {rh, rl}, {32'h0, 32'hF});
        check("3x5 latency", lat, 33);
        check("3x5 busy cycles", bcnt, 32);

        run_op(1, 0, 32'hFFFF_FFFE, 32'd3, -1, lat, bcnt, rh, rl, rdz);
        check("-2x3 result", {rh, rl}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});

        run_op(1, 0, 32'h8000_0000, 32'h8000_0000, -1, lat, bcnt, rh, rl, rdz);
        check("minint^2 result", {rh, rl}, {32'h4000_0000, 32'h0});

        run_op(0, 1, 32'd7, 32'hFFFF_FFFE, -1, lat, bcnt, rh, rl, rdz);
        check("7/-2 result", {rh, rl}, {32'h1, 32'hFFFF_FFFD});
        check("7/-2 latency", lat, 33);

        run_op(0, 1, 32'hFFFF_FFF9, 32'd2, -1, lat, bcnt, rh, rl, rdz);
        check("-7/2 result", {rh, rl}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        run_op(0, 1, 32'd5, 32'd0, -1, lat, bcnt, rh, rl, rdz);
`ifdef DIV_ZERO_TRAP_EN
        check("5/0 hi/lo kept", {rh, rl}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        check("5/0 div_by_zero", rdz, 1'b1);
        check("5/0 latency", lat, 2);
`else
        check("5/0 forced result", {rh, rl}, {32'h5, 32'hFFFF_FFFF});
        check("5/0 div_by_zero", rdz, 1'b0);
        check("5/0 latency", lat, 33);
`endif

        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, bcnt, rh, rl, rdz);
        check("minint/-1 wrap", {rh, rl}, {32'h0, 32'h8000_0000});

        run_op(1, 1, 32'd6, 32'd7, -1, lat, bcnt, rh, rl, rdz);
        check("both starts -> mult", {rh, rl}, {32'h0, 32'd42});
        check("both starts latency", lat, 33);

        run_op(1, 0, 32'd9, 32'hFFFF_FFFF, 10, lat, bcnt, rh, rl, rdz);
        check("mid-MULT start_div result", {rh, rl}, {32'hFFFF_FFFF, 32'hFFFF_FFF7});
        check("mid-MULT start_div latency", lat, 33);
        repeat (3) @(negedge clock);
        check("stray start_div not queued", busy, 1'b0);

        // Reset in the middle of a divide.
        @(negedge clock);
        start_div = 1'b1; op_a = 32'd100; op_b = 32'd7; n_vec++;
        @(negedge clock);
        start_div = 1'b0;
        repeat (9) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
        check("reset mid-DIV", {busy, done, div_by_zero, hi, lo}, 67'd0);
        reset = 1'b0;

        run_op(0, 1, 32'd100, 32'd7, -1, lat, bcnt, rh, rl, rdz);
        check("fresh div after reset", {rh, rl}, {32'd2, 32'd14});
        check("fresh div latency", lat, 33);

        // Randomised back-to-back operations with stray starts while busy.
        for (int i = 0; i < 30; i++) begin
            sm = 1'($urandom_range(0, 1));
            sd = !sm || 1'($urandom_range(0, 1));
            ra = pick();
            rb = pick();
`ifdef DIV_ZERO_TRAP_EN
            exp_lat = (!sm && rb == '0) ? 2 : 33;
`else
            exp_lat = 33;
`endif
            run_op(sm, sd, ra, rb, (exp_lat == 2) ? -1 : $urandom_range(1, 30), lat, bcnt, rh, rl, rdz);
            check("random op latency", lat, exp_lat);
        end

        // Free-running random start pulses; the per-cycle model judges acceptance.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            start_mult = ($urandom_range(0, 7) == 0);
            start_div  = ($urandom_range(0, 7) == 0);
            op_a = pick();
            op_b = pick();
            n_vec++;
        end
        @(negedge clock);
        start_mult = 1'b0;
        start_div = 1'b0;
        repeat (40) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
